// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared encodings for the multicycle MIPS control path: opcodes, FSM state
// codes, datapath mux encodings and fault codes.
// No ports; imported by the controller, its wait timer and the bus interface.
// -----------------------------------------------------------------------------
package mips_pkg;

  // Opcodes recognised by the controller (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // FSM state encoding; codes 11-15 are never produced by the next-state logic
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Operation requested from alu_control
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // Reason the core stopped
  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_t;

  // States that hold a memory request open until mem_ready
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the multicycle controller and the rest of the core.
//   master : controller side (takes opcode/mem_ready, drives selects/strobes)
//   slave  : datapath/memory side (the mirror image)
// Signals:
//   opcode, mem_ready                  : status into the controller
//   pc_wr, pc_wr_cond, pc_src, ir_wr   : PC / instruction register control
//   iord, mem_rd, mem_wr               : memory address select and requests
//   mem_to_reg, reg_dst, rf_wr         : register file write control
//   alu_src_a, alu_src_b, aluop        : ALU operand selects and operation
//   halt, fault, state, instr_count    : status / debug
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int CNT_W = 32
);

  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_wr;
  logic             pc_wr_cond;
  logic [1:0]       pc_src;
  logic             ir_wr;
  logic             iord;
  logic             mem_rd;
  logic             mem_wr;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             rf_wr;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       aluop;
  logic             halt;
  logic [1:0]       fault;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output pc_wr, pc_wr_cond, pc_src, ir_wr, iord, mem_rd, mem_wr,
           mem_to_reg, reg_dst, rf_wr, alu_src_a, alu_src_b, aluop,
           halt, fault, state, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_wr, pc_wr_cond, pc_src, ir_wr, iord, mem_rd, mem_wr,
           mem_to_reg, reg_dst, rf_wr, alu_src_a, alu_src_b, aluop,
           halt, fault, state, instr_count
  );

endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles a memory request has been left waiting and flags when the
// allowed budget is used up.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count (controller is changing state)
//   waiting    : request outstanding and mem_ready low this cycle
//   expired    : budget exhausted and memory still not ready
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  // The controller always leaves the state once expired is seen, so clear
  // fires before the counter can ever step past TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (waiting) begin
      count_q <= count_q + 1'b1;
    end
  end

  // A ready arriving on the cycle the count hits TIMEOUT still wins
  assign expired = waiting && (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Sequencing FSM for the multicycle MIPS core. Steps each instruction through
// fetch/decode/execute/memory/writeback over a shared single-ported memory,
// counts retired instructions and stops on illegal opcodes, the halt opcode
// or a memory request that never completes.
//   clk    : clock
//   reset  : synchronous active-high reset
//   bus    : multicycle_control_if.master (opcode/mem_ready in, all datapath
//            selects, strobes and status out)
// -----------------------------------------------------------------------------
module multicycle_control
  import mips_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  state_t           state_q;
  state_t           state_d;
  fault_t           fault_q;
  fault_t           fault_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic             waiting;
  logic             timer_clear;
  logic             expired;

  // Any state change restarts the wait budget, which covers entry to each
  // of the memory-wait states.
  assign waiting     = is_wait_state(state_q) && !bus.mem_ready;
  assign timer_clear = (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .waiting (waiting),
    .expired (expired)
  );

  // State register plus the fault latch and retire counter. The fault code
  // is captured only on the transition into HALT so it stays sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      fault_q <= FAULT_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_HALT && state_q != S_HALT) begin
        fault_q <= fault_d;
      end
      if (retire) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    fault_d = FAULT_NONE;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_HALT:      state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (expired) begin
          state_d = S_HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (expired) begin
          state_d = S_HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      S_R_EXEC: state_d = S_R_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        fault_d = FAULT_ILLEGAL;
      end
    endcase
  end

  // Output decode: Moore on state, except the FETCH PC/IR writes which
  // follow mem_ready so the fetched word is captured the cycle it arrives.
  always_comb begin
    bus.pc_wr      = 1'b0;
    bus.pc_wr_cond = 1'b0;
    bus.pc_src     = PCSRC_ALU;
    bus.ir_wr      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.rf_wr      = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_RT;
    bus.aluop      = ALUOP_ADD;
    bus.halt       = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_rd    = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.pc_wr     = bus.mem_ready;
        bus.ir_wr     = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        bus.mem_rd = 1'b1;
        bus.iord   = 1'b1;
      end
      S_MEM_WB: begin
        bus.rf_wr      = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_wr = 1'b1;
        bus.iord   = 1'b1;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.aluop     = ALUOP_FUNCT;
      end
      S_R_WB: begin
        bus.rf_wr   = 1'b1;
        bus.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a  = 1'b1;
        bus.aluop      = ALUOP_SUB;
        bus.pc_wr_cond = 1'b1;
        bus.pc_src     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        bus.pc_wr  = 1'b1;
        bus.pc_src = PCSRC_JUMP;
      end
      S_HALT: begin
        bus.halt = 1'b1;
      end
      default: begin
        bus.halt = 1'b0;
      end
    endcase
    // Reset silences every strobe immediately, before the state register
    // has been reloaded.
    if (reset) begin
      bus.pc_wr      = 1'b0;
      bus.pc_wr_cond = 1'b0;
      bus.ir_wr      = 1'b0;
      bus.rf_wr      = 1'b0;
      bus.mem_rd     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.halt       = 1'b0;
    end
  end

  assign bus.fault       = fault_q;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequencing controller for the multicycle build of the MIPS core.
- Instruction fetch and data access share one single-ported Memory with a variable-latency ready handshake.
- One FSM steps each instruction through fetch/decode/execute/memory/writeback and drives every mux select and write strobe of the datapath.
- Tracks retired-instruction count; detects illegal opcodes and memory timeouts, both ending in a sticky halt.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TIMEOUT, 16, max cycles a memory request may wait for mem_ready before a fault halt (must be >=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  instr[31:26] from instruction register.
- mem_ready  input  1  memory completes current read/write this cycle.
- pc_wr  output  1  unconditional PC write.
- pc_wr_cond  output  1  PC write if alu_zero (datapath ANDs it).
- pc_src  output  2  00 ALU result, 01 ALUOut register, 10 jump target.
- ir_wr  output  1  load instruction register.
- iord  output  1  memory address select: 0 PC, 1 ALUOut.
- mem_rd  output  1  memory read request.
- mem_wr  output  1  memory write request.
- mem_to_reg  output  1  RF write data: 0 ALUOut, 1 memory data register.
- reg_dst  output  1  RF write reg: 0 rt, 1 rd.
- rf_wr  output  1  register file write enable.
- alu_src_a  output  1  0 PC, 1 rs data.
- alu_src_b  output  2  00 rt data, 01 constant 4, 10 imm32, 11 imm32<<2.
- aluop  output  2  to alu_control: 00 add, 01 sub, 10 funct.
- halt  output  1  sticky stop; gates clock externally.
- fault  output  2  00 none, 01 illegal opcode, 10 memory timeout.
- state  output  4  current state encoding (debug).
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, HALT=10. Codes 11-15 are unreachable; if entered, go to HALT with fault=01.
- Opcodes: R=0x00, lw=0x23, sw=0x2B, beq=0x04, j=0x02, halt=0x3F.
- Reset: state=FETCH, fault=00, instr_count=0, wait counter=0.
  - While reset is high, all strobes (pc_wr, pc_wr_cond, ir_wr, rf_wr, mem_rd, mem_wr) are forced 0 and halt=0.
  - Reset overrides any state, including HALT and a pending memory wait.
- Outputs are decoded from state (Moore), except pc_wr/ir_wr in FETCH, which equal mem_ready. Any signal not listed for a state is 0.
- FETCH:
  - Drives mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_src=00.
  - Stays until mem_ready; then pc_wr=ir_wr=1 in the same cycle and goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, aluop=00 (branch target into ALUOut).
  - Next state by opcode: R->R_EXEC, lw/sw->MEM_ADDR, beq->BRANCH, j->JUMP, halt->HALT.
  - Any other opcode -> HALT with fault=01.
- MEM_ADDR: drives alu_src_a=1, alu_src_b=10, aluop=00. Goes to MEM_RD if opcode=lw, else MEM_WR.
- MEM_RD: drives mem_rd=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: drives rf_wr=1, mem_to_reg=1, reg_dst=0. Retires, then FETCH.
- MEM_WR: drives mem_wr=1, iord=1. Waits for mem_ready, then retires and goes to FETCH.
- R_EXEC: drives alu_src_a=1, alu_src_b=00, aluop=10. Next R_WB.
- R_WB: drives rf_wr=1, reg_dst=1, mem_to_reg=0. Retires, then FETCH.
- BRANCH: drives alu_src_a=1, alu_src_b=00, aluop=01, pc_wr_cond=1, pc_src=01. Retires, then FETCH.
- JUMP: drives pc_wr=1, pc_src=10. Retires, then FETCH.
- HALT: halt=1 and all strobes 0. Stays until reset. The halt opcode does not retire.
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R 4, beq 3, j 3.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - When the counter reaches TIMEOUT with mem_ready still 0, the next state is HALT with fault=10.
  - mem_ready on the cycle the count reaches TIMEOUT wins; no fault is raised.
- instr_count: increments by 1 on each retire and wraps modulo 2^CNT_W.
- fault: written only on entry to HALT; holds until reset.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants;
  - state encoding localparams;
  - alu_src_b, pc_src and aluop encodings;
  - fault codes.
- Sub-module mem_wait_timer holds the wait counter and timeout compare (inputs: clear, waiting; output: expired).
- FSM next-state logic and output decode stay in multicycle_control.

Test Plan:
- Zero-wait, mem_ready=1 always: program R(0x00), lw(0x23), sw(0x2B), beq(0x04), j(0x02), halt(0x3F). Expect state sequences of 4/5/4/3/3 cycles, then HALT with instr_count=5 and fault=00.
- lw with mem_ready low 3 cycles in MEM_RD: mem_rd=1 and iord=1 held 4 cycles; rf_wr pulses exactly once in MEM_WB.
- FETCH with mem_ready low for TIMEOUT=16 cycles: HALT, fault=10, halt=1. Same test with ready arriving on cycle 16: DECODE, fault=00.
- Opcode 0x3E in DECODE: next state HALT, fault=01, instr_count unchanged.
- Reset asserted mid-MEM_WR with mem_wr=1: next cycle state=FETCH, mem_wr=0 during reset, instr_count=0. Reset also releases HALT.
- CNT_W=4: retire 16 R-type instructions; instr_count wraps 15->0.
